// File: rtl/spdr_push_arb_if.sv
// Requester-side and FIFO write-side signals of the spdr_push_arb arbiter.
// The arbiter uses the master modport. The requesters and the FIFO use the slave modport.
interface spdr_push_arb_if #(
    parameter int DW = 8
);
    logic [3:0]      req;
    logic [4*DW-1:0] req_data;
    logic [3:0]      req_last;
    logic [3:0]      req_ack;
    logic [3:0]      gnt;
    logic [DW-1:0]   fifo_din;
    logic            fifo_push;
    logic            fifo_full;
    logic            burst_err;

    modport master (
        input  req, req_data, req_last, fifo_full,
        output req_ack, gnt, fifo_din, fifo_push, burst_err
    );

    modport slave (
        output req, req_data, req_last, fifo_full,
        input  req_ack, gnt, fifo_din, fifo_push, burst_err
    );
endinterface

// File: rtl/spdr_push_arb.sv
// Four-way round-robin arbiter that pushes requester beats into a FIFO.
// Define SPDR_ARB_PKT_LOCK_EN to keep the grant for a whole packet, ending on req_last or after MAX_BURST beats.
module spdr_push_arb #(
    parameter int DW        = 8,
    parameter int MAX_BURST = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    spdr_push_arb_if.master   bus
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    logic [0:0] state;
    logic [3:0] gnt_q;
    logic [1:0] last_winner;
    logic [1:0] own_idx;
    logic       own_req;
    logic       own_last;
    logic       transfer;
    logic       release_pt;
    logic       burst_hit;
    logic       pick_valid;
    logic [1:0] pick_idx;

    always_comb begin
        own_idx = 2'd0;
        case (gnt_q)
            4'b0010: own_idx = 2'd1;
            4'b0100: own_idx = 2'd2;
            4'b1000: own_idx = 2'd3;
            default: own_idx = 2'd0;
        endcase
    end

    assign own_req  = bus.req[own_idx];
    assign own_last = bus.req_last[own_idx];
    assign transfer = (state == ST_OWN) & own_req & ~bus.fifo_full & ~rst_in;

    // last_winner always equals the current owner while in OWN, so a single
    // search starting after it serves both the idle grant and the re-arbitration
    // (the owner naturally falls to lowest priority).
    always_comb begin
        logic [1:0] cand;
        pick_valid = 1'b0;
        pick_idx   = 2'd0;
        cand       = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = last_winner + 2'd1 + 2'(k);
            if (!pick_valid && bus.req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

`ifdef SPDR_ARB_PKT_LOCK_EN
    logic [7:0] beat_cnt;
    logic       locked;
    logic       burst_err_q;

    assign burst_hit  = transfer & ~own_last &
                        ((9'({1'b0, beat_cnt}) + 9'd1) == 9'(MAX_BURST));
    assign release_pt = (state == ST_OWN) &
                        ((transfer & (own_last | burst_hit)) | (~locked & ~own_req));
    assign bus.burst_err = burst_err_q;
`else
    assign burst_hit     = 1'b0;
    assign release_pt    = (state == ST_OWN) & (transfer | ~own_req);
    assign bus.burst_err = 1'b0;
`endif

    assign bus.gnt       = gnt_q;
    assign bus.fifo_push = transfer;
    assign bus.req_ack   = gnt_q & {4{transfer}};
    assign bus.fifo_din  = bus.req_data[own_idx*DW +: DW];

    // Grant FSM: the new winner is latched on the edge that ends a release cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= ST_IDLE;
            gnt_q       <= 4'b0000;
            last_winner <= 2'd3;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state       <= ST_OWN;
                        gnt_q       <= 4'(4'b0001 << pick_idx);
                        last_winner <= pick_idx;
                    end
                end
                default: begin
                    if (release_pt) begin
                        if (pick_valid) begin
                            gnt_q       <= 4'(4'b0001 << pick_idx);
                            last_winner <= pick_idx;
                        end else begin
                            state <= ST_IDLE;
                            gnt_q <= 4'b0000;
                        end
                    end
                end
            endcase
        end
    end

`ifdef SPDR_ARB_PKT_LOCK_EN
    // Packet lock tracking: the counter only runs while a multi-beat packet owns the FIFO.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            beat_cnt    <= 8'd0;
            locked      <= 1'b0;
            burst_err_q <= 1'b0;
        end else begin
            if (burst_hit)
                burst_err_q <= 1'b1;
            if (release_pt) begin
                beat_cnt <= 8'd0;
                locked   <= 1'b0;
            end else if (transfer) begin
                beat_cnt <= beat_cnt + 8'd1;
                locked   <= 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_spdr_push_arb.sv
// Directed bench for spdr_push_arb; expectations follow SPDR_ARB_PKT_LOCK_EN when it is defined.
module tb_spdr_push_arb;
    logic clk_in = 1'b0;
    logic rst_in;

    spdr_push_arb_if #(.DW(8)) bus ();

    spdr_push_arb #(.DW(8), .MAX_BURST(4)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int compared   = 0;
    int mismatched = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later, well away from the rising edge.
    task automatic applyStimulus(input logic rst, input logic [3:0] req, input logic [3:0] last, input logic full);
        @(negedge clk_in);
        rst_in        = rst;
        bus.req       = req;
        bus.req_last  = last;
        bus.fifo_full = full;
        #1;
    endtask

    task automatic checkCycle(input string tag, input logic [3:0] g, input logic [3:0] ack,
                              input logic push, input logic [7:0] din);
        checkOutput({tag, " gnt"},  32'(bus.gnt),       32'(g));
        checkOutput({tag, " ack"},  32'(bus.req_ack),   32'(ack));
        checkOutput({tag, " push"}, 32'(bus.fifo_push), 32'(push));
        if (push)
            checkOutput({tag, " din"}, 32'(bus.fifo_din), 32'(din));
    endtask

    logic [3:0] expG [0:5];
    logic [7:0] expD [0:5];
    logic       expE [0:5];

    initial begin
        rst_in        = 1'b1;
        bus.req       = 4'b0000;
        bus.req_last  = 4'b0000;
        bus.fifo_full = 1'b0;
        bus.req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
        checkCycle("reset", 4'b0000, 4'b0000, 1'b0, 8'h00);
        checkOutput("reset burst_err", 32'(bus.burst_err), 32'd0);

        // Round-robin with all requesters pending.
        applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b0);
        checkCycle("rr idle", 4'b0000, 4'b0000, 1'b0, 8'h00);
        expG[0] = 4'b0001; expG[1] = 4'b0010; expG[2] = 4'b0100;
        expG[3] = 4'b1000; expG[4] = 4'b0001;
        expD[0] = 8'hA0; expD[1] = 8'hB1; expD[2] = 8'hC2; expD[3] = 8'hD3; expD[4] = 8'hA0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b0);
            checkCycle($sformatf("rr beat%0d", i), expG[i], expG[i], 1'b1, expD[i]);
        end

        // Reset while owner 1 holds the grant.
        applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b0);
        checkOutput("midrst push", 32'(bus.fifo_push), 32'd0);
        checkOutput("midrst ack",  32'(bus.req_ack),   32'd0);
        applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b0);
        checkCycle("postrst idle", 4'b0000, 4'b0000, 1'b0, 8'h00);
        applyStimulus(1'b0, 4'b1111, 4'b0000, 1'b0);
        checkCycle("postrst first", 4'b0001, 4'b0001, 1'b1, 8'hA0);

        // Owner 2 stalled by a full FIFO.
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
        applyStimulus(1'b0, 4'b0100, 4'b0000, 1'b0);
        checkCycle("full idle", 4'b0000, 4'b0000, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 4'b0100, 4'b0000, 1'b1);
            checkCycle($sformatf("full stall%0d", i), 4'b0100, 4'b0000, 1'b0, 8'h00);
        end
        applyStimulus(1'b0, 4'b0100, 4'b0000, 1'b0);
        checkCycle("full clear", 4'b0100, 4'b0100, 1'b1, 8'hC2);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
        checkCycle("drop req", 4'b0100, 4'b0000, 1'b0, 8'h00);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
`ifdef SPDR_ARB_PKT_LOCK_EN
        checkCycle("locked hold", 4'b0100, 4'b0000, 1'b0, 8'h00);
`else
        checkCycle("back to idle", 4'b0000, 4'b0000, 1'b0, 8'h00);
`endif

        // Requester 0 sends a 3-beat packet while requester 1 waits.
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
        applyStimulus(1'b0, 4'b0011, 4'b0000, 1'b0);
        checkCycle("pkt idle", 4'b0000, 4'b0000, 1'b0, 8'h00);
`ifdef SPDR_ARB_PKT_LOCK_EN
        applyStimulus(1'b0, 4'b0011, 4'b0000, 1'b0);
        checkCycle("pkt beat0", 4'b0001, 4'b0001, 1'b1, 8'hA0);
        applyStimulus(1'b0, 4'b0011, 4'b0000, 1'b0);
        checkCycle("pkt beat1", 4'b0001, 4'b0001, 1'b1, 8'hA0);
        applyStimulus(1'b0, 4'b0011, 4'b0001, 1'b0);
        checkCycle("pkt beat2", 4'b0001, 4'b0001, 1'b1, 8'hA0);
        applyStimulus(1'b0, 4'b0010, 4'b0000, 1'b0);
        checkCycle("pkt next", 4'b0010, 4'b0010, 1'b1, 8'hB1);
`else
        expG[0] = 4'b0001; expG[1] = 4'b0010; expG[2] = 4'b0001;
        expG[3] = 4'b0010; expG[4] = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 4'b0011, (i == 2) ? 4'b0001 : 4'b0000, 1'b0);
            checkCycle($sformatf("alt beat%0d", i), expG[i], expG[i], 1'b1,
                       (expG[i] == 4'b0001) ? 8'hA0 : 8'hB1);
        end
`endif
        checkOutput("pkt burst_err", 32'(bus.burst_err), 32'd0);

        // Requester 0 streams without last while requester 1 waits; MAX_BURST is 4.
        applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
        applyStimulus(1'b0, 4'b0011, 4'b0000, 1'b0);
        checkCycle("burst idle", 4'b0000, 4'b0000, 1'b0, 8'h00);
`ifdef SPDR_ARB_PKT_LOCK_EN
        expG[0] = 4'b0001; expG[1] = 4'b0001; expG[2] = 4'b0001;
        expG[3] = 4'b0001; expG[4] = 4'b0010; expG[5] = 4'b0010;
        expE[0] = 1'b0; expE[1] = 1'b0; expE[2] = 1'b0;
        expE[3] = 1'b0; expE[4] = 1'b1; expE[5] = 1'b1;
`else
        expG[0] = 4'b0001; expG[1] = 4'b0010; expG[2] = 4'b0001;
        expG[3] = 4'b0010; expG[4] = 4'b0001; expG[5] = 4'b0010;
        for (int i = 0; i < 6; i++) expE[i] = 1'b0;
`endif
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 4'b0011, 4'b0000, 1'b0);
            checkCycle($sformatf("burst beat%0d", i), expG[i], expG[i], 1'b1,
                       (expG[i] == 4'b0001) ? 8'hA0 : 8'hB1);
            checkOutput($sformatf("burst err%0d", i), 32'(bus.burst_err), 32'(expE[i]));
        end

        applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b0);
        checkOutput("final rst push", 32'(bus.fifo_push), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/spdr_push_arb.md
SPDR_PUSH_ARB -- requirements
Module: spdr_push_arb

Interface
REQ-001 Parameter DW, default 8: data width of every requester and of the FIFO write port.
REQ-002 Parameter MAX_BURST, default 16: maximum beats per locked packet, range 2..255.
REQ-003 clk_in  input  1  sole clock; every register updates on its rising edge.
REQ-004 rst_in  input  1  reset, synchronous, active-high.
REQ-005 req  input  4  per-requester beat-valid.
REQ-006 req_data  input  4*DW  requester i data on bits [i*DW +: DW].
REQ-007 req_last  input  4  per-requester end-of-packet marker qualifying the current beat.
REQ-008 req_ack  output  4  one-hot pulse: requester i's beat was written into the FIFO this cycle.
REQ-009 gnt  output  4  one-hot current owner; all-zero when idle.
REQ-010 fifo_din  output  DW  FIFO write data.
REQ-011 fifo_push  output  1  FIFO write strobe.
REQ-012 fifo_full  input  1  FIFO full flag from the write-side clock domain.
REQ-013 burst_err  output  1  sticky flag: a locked packet exceeded MAX_BURST beats.

Function
REQ-014 The FSM has two states: IDLE (gnt=0) and OWN (gnt one-hot, owner index g).
REQ-015 In IDLE with req!=0, the block latches the round-robin winner into gnt and enters OWN on the next edge; no beat transfers in IDLE.
REQ-016 Round-robin order: search starts at index (last_winner+1) mod 4 and ascends with wrap; last_winner resets to 3, so requester 0 wins first.
REQ-017 In OWN, transfer = req[g] & !fifo_full, combinational in the same cycle.
REQ-018 fifo_push = transfer, fifo_din = req_data slice g, and req_ack = gnt & {4{transfer}}.
REQ-019 fifo_push is never asserted while fifo_full=1; no beat is dropped or duplicated.
REQ-020 Release point: in OWN, a transfer while the block is not locked, or req[g]=0 while the block is not locked.
REQ-021 At a release point the next gnt is the round-robin winner over the current req vector with g masked to lowest priority; if no requester is pending, the FSM returns to IDLE.
REQ-022 Re-arbitration at a release point is same-cycle, so back-to-back beats from different requesters incur no bubble.
REQ-023 last_winner updates to the index of every new grant.
REQ-024 While fifo_full=1 and not at a release point, gnt holds and req_ack=0.

Reset
REQ-025 With rst_in=1 at an edge: state=IDLE, gnt=0, last_winner=3, beat counter=0, locked=0, burst_err=0.
REQ-026 req_ack=0 and fifo_push=0 during any cycle with rst_in=1, regardless of other inputs.
REQ-027 A reset mid-packet abandons the packet; no further beats are pushed until a new grant.

Configuration
REQ-028 Macro SPDR_ARB_PKT_LOCK_EN defined: the first transfer of a packet without req_last sets locked.
REQ-029 With the macro defined, release occurs only on the transfer carrying req_last=1.
REQ-030 With the macro defined, the 8-bit beat counter counts transfers within a locked packet.
REQ-031 With the macro defined, on the MAX_BURST-th transfer without last, the block sets burst_err, clears locked, and releases.
REQ-032 With the macro defined, req[g]=0 while locked holds the grant with no release.
REQ-033 Macro undefined: req_last is ignored, locked stays 0, every transfer is a release point, and burst_err is tied 0.

Verification
REQ-034 Reset, then req=4'b1111 held, fifo_full=0 -> grants 0,1,2,3,0 on consecutive transfers, one req_ack per cycle, no bubble after the first cycle.
REQ-035 Owner 2 active, fifo_full=1 for 5 cycles -> fifo_push=0 and gnt=4'b0100 throughout; the data beat is pushed on the first cycle after full clears.
REQ-036 Lock enabled, req0 3-beat packet (last on beat 3) with req1 pending -> beats 0,0,0 then requester 1; no interleave.
REQ-037 Lock enabled, MAX_BURST=4, req0 streams 6 beats with no last -> 4 pushes, burst_err=1, grant moves to the pending requester.
REQ-038 Lock disabled, same stimulus as REQ-036 -> strict per-beat alternation 0,1,0,1,0.
REQ-039 rst_in asserted mid-packet -> next cycle gnt=0 and fifo_push=0; after release of reset, requester 0 wins first.
